fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. It owns the architectural PC register, drives the instruction-memory read port, and loads the IF/ID pipeline register. It supplies the current PC to the PC-control block and consumes its next-PC result. It absorbs memory wait states, hazard stalls, branch flushes and halt.

## Interface
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_INSTR, 16'h0000: bubble encoding written into IF/ID.
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- next_pc  in  16  next PC from PC control (PC+2, branch target or register target).
- pc  out  16  current PC; feeds PC control and imem_addr.
- pc_hold  out  1  high when the PC will not advance this cycle; drives PC control's hold (hlt) input.
- imem_addr  out  16  equals pc.
- imem_rd_en  out  1  read request.
- imem_data  in  16  fetched instruction.
- imem_ready  in  1  imem_data valid this cycle.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- flush  in  1  taken branch resolved in ID; redirect to next_pc and squash IF/ID.
- if_id_instr  out  16  registered instruction.
- if_id_pc2  out  16  registered pc+2.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HLT.

## Operation
- FSM states: FETCH, WAIT_MEM, HALTED. Reset state is FETCH.
- Event priority each cycle: flush > stall > memory wait > normal.
- **FETCH**
  - imem_rd_en=1.
  - If imem_ready: pc<=next_pc; IF/ID<={imem_data, pc+2, valid=1}.
  - If not imem_ready: go to WAIT_MEM; pc holds; IF/ID<=bubble (NOP_INSTR, valid=0).
- **WAIT_MEM**
  - imem_rd_en stays 1 and imem_addr is unchanged.
  - On imem_ready, accept exactly as in FETCH and return to FETCH.
- **HLT detection**
  - An accepted instruction with imem_data[15:12]==4'hF is written to IF/ID with valid=1.
  - pc is not updated; next state is HALTED.
- **HALTED**
  - imem_rd_en=0; pc frozen; IF/ID<=bubble each cycle; halted=1.
- **flush** (any state)
  - pc<=next_pc; IF/ID<=bubble; next state FETCH.
  - A flush in HALTED cancels the halt, because the HLT was on the wrong path.
- **stall** (without flush)
  - pc, IF/ID and FSM state all hold.
  - Any pending imem_ready is ignored; the same address is re-read after the stall.
- pc_hold = !(flush | (accepting & !is_hlt)).
- Arithmetic: pc+2 wraps modulo 2^16, so 16'hFFFE+2=16'h0000. No overflow flag.

## Timing
- Reset values (async, immediate):
  - pc=RESET_PC
  - if_id_instr=NOP_INSTR
  - if_id_pc2=16'h0000
  - if_id_valid=0
  - halted=0
  - state FETCH
  - counters 0
- Single-cycle latency: an instruction accepted in cycle N is visible in IF/ID in cycle N+1, and pc equals next_pc in cycle N+1.
- imem read is combinational within the cycle and is sampled at the rising edge when imem_ready=1.
- Reset asserted mid-WAIT_MEM or in HALTED returns to FETCH at RESET_PC with no residual valid.
- stall and flush in the same cycle: flush wins.

## Configuration
- FETCH_PERF_CNT_EN
  - **Defined:** adds outputs fetch_cnt[15:0] and bubble_cnt[15:0], both saturating at 16'hFFFF.
    - fetch_cnt increments on every accepted instruction.
    - bubble_cnt increments on every cycle IF/ID loads a bubble.
    - Neither counter counts stall-hold cycles.
  - **Undefined:** the ports and the counter logic are absent.

## Structure
- Package fetch_pkg:
  - state enum fetch_state_t
  - OPC_HLT=4'hF
  - default RESET_PC and NOP_INSTR constants
- Sub-module if_id_reg: the pipeline register with async active-low reset, hold, load and bubble controls.
- fetch_stage contains the FSM, the PC register, and the pc+2 adder (a cla_16 instance).

## Test plan
- Reset release with imem_ready=1 and next_pc=pc+2 -> pc steps 0000, 0002, 0004; if_id_pc2 lags pc by one cycle; if_id_valid=1 from cycle 2.
- imem_ready low for 3 cycles at pc=0x0010 -> pc holds 0x0010; 3 bubbles with valid=0; bubble_cnt=3; instruction accepted on the 4th cycle.
- stall for 2 cycles with IF/ID holding 0x1234 -> IF/ID and pc are unchanged; pc_hold=1 throughout.
- flush with next_pc=0x0100 during WAIT_MEM -> next cycle pc=0x0100, if_id_valid=0, state FETCH.
- Fetch of 0xF000 at pc=0x0020 -> IF/ID holds 0xF000 with valid=1; pc stays 0x0020; halted=1; imem_rd_en=0. A subsequent flush to 0x0040 resumes fetch.
- rst_n pulsed low while halted -> outputs reset immediately (asynchronously); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      WAIT_MEM = 2'd1,
      HALTED   = 2'd2
   } fetch_state_t;

   localparam logic [3:0]  OPC_HLT   = 4'hF;
   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_stage_cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups chained on
// their group generate/propagate terms.
module cla_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ci,
   output logic [15:0] sum
);

   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic        carry;

   assign p = a ^ b;
   assign g = a & b;

   // Per-group lookahead carries; carry ripples only between groups.
   always_comb begin
      c     = '0;
      carry = ci;
      for (int grp = 0; grp < 4; grp++) begin
         c[4*grp]   = carry;
         c[4*grp+1] = g[4*grp] | (p[4*grp] & carry);
         c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                    | (p[4*grp+1] & p[4*grp] & carry);
         c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                    | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                    | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & carry);
         carry      = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                    | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                    | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                    | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & carry);
      end
   end

   assign sum = p ^ c;

endmodule

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. hold wins over load, load wins over bubble;
// with none asserted the register keeps its contents.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        load,
   input  logic        bubble,
   input  logic [15:0] instr_in,
   input  logic [15:0] pc2_in,
   output logic [15:0] instr,
   output logic [15:0] pc2,
   output logic        valid
);

   // Pipeline register update; a bubble also clears the stored pc+2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= NOP_INSTR;
         pc2   <= 16'h0000;
         valid <= 1'b0;
      end else if (hold) begin
         instr <= instr;
         pc2   <= pc2;
         valid <= valid;
      end else if (load) begin
         instr <= instr_in;
         pc2   <= pc2_in;
         valid <= 1'b1;
      end else if (bubble) begin
         instr <= NOP_INSTR;
         pc2   <= 16'h0000;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem read request, IF/ID load.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | issuing a read at pc, accepting when imem_ready
// WAIT_MEM | memory wait state, same address re-read, IF/ID gets bubbles
// HALTED   | HLT accepted; no reads, pc frozen until a flush
module fetch_stage
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] next_pc,
   output logic [15:0] pc,
   output logic        pc_hold,
   output logic [15:0] imem_addr,
   output logic        imem_rd_en,
   input  logic [15:0] imem_data,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        flush,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc2,
   output logic        if_id_valid,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] fetch_cnt,
   output logic [15:0] bubble_cnt
`endif
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic         accepting;
   logic         is_hlt;
   logic         ifid_hold;
   logic         ifid_load;
   logic         ifid_bubble;
   logic [15:0]  pc_plus2;

   assign is_hlt    = (imem_data[15:12] == OPC_HLT);
   assign imem_addr = pc;
   assign halted    = (state == HALTED);

   cla_16 u_pc_add (
      .a   (pc),
      .b   (16'h0002),
      .ci  (1'b0),
      .sum (pc_plus2)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   // Next state and IF/ID control; flush beats stall beats memory wait.
   always_comb begin
      state_nxt   = state;
      accepting   = 1'b0;
      ifid_hold   = 1'b0;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      imem_rd_en  = (state != HALTED);
      if (flush) begin
         state_nxt   = FETCH;
         ifid_bubble = 1'b1;
      end else if (stall) begin
         ifid_hold = 1'b1;
      end else begin
         case (state)
            FETCH, WAIT_MEM: begin
               if (imem_ready) begin
                  accepting = 1'b1;
                  ifid_load = 1'b1;
                  state_nxt = is_hlt ? HALTED : FETCH;
               end else begin
                  ifid_bubble = 1'b1;
                  state_nxt   = WAIT_MEM;
               end
            end
            HALTED: ifid_bubble = 1'b1;
            default: begin
               ifid_bubble = 1'b1;
               state_nxt   = FETCH;
            end
         endcase
      end
      pc_hold = !(flush | (accepting & !is_hlt));
   end

   // PC advances on a flush redirect or a non-HLT accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pc <= RESET_PC;
      else if (!pc_hold) pc <= next_pc;
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (ifid_hold),
      .load     (ifid_load),
      .bubble   (ifid_bubble),
      .instr_in (imem_data),
      .pc2_in   (pc_plus2),
      .instr    (if_id_instr),
      .pc2      (if_id_pc2),
      .valid    (if_id_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   // Saturating counters; stall-hold cycles are neither accepts nor bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt  <= 16'h0000;
         bubble_cnt <= 16'h0000;
      end else begin
         if (accepting && fetch_cnt != 16'hFFFF)    fetch_cnt  <= fetch_cnt + 16'h0001;
         if (ifid_bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process pushes the expected
// per-cycle outputs, a monitor pops and compares on every falling edge.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] next_pc;
   logic [15:0] pc;
   logic        pc_hold;
   logic [15:0] imem_addr;
   logic        imem_rd_en;
   logic [15:0] imem_data;
   logic        imem_ready;
   logic        stall;
   logic        flush;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc2;
   logic        if_id_valid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt;
   logic [15:0] bubble_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string       tag;
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] pc2;
      logic        val;
      logic        halt;
      logic        rd;
      logic        hold;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .next_pc     (next_pc),
      .pc          (pc),
      .pc_hold     (pc_hold),
      .imem_addr   (imem_addr),
      .imem_rd_en  (imem_rd_en),
      .imem_data   (imem_data),
      .imem_ready  (imem_ready),
      .stall       (stall),
      .flush       (flush),
      .if_id_instr (if_id_instr),
      .if_id_pc2   (if_id_pc2),
      .if_id_valid (if_id_valid),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .bubble_cnt  (bubble_cnt)
`endif
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares whatever the stimulus queued for this cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, " pc"},        pc,                   e.pc);
         chk({e.tag, " imem_addr"}, imem_addr,            e.pc);
         chk({e.tag, " instr"},     if_id_instr,          e.instr);
         chk({e.tag, " valid"},     {15'd0, if_id_valid}, {15'd0, e.val});
         chk({e.tag, " halted"},    {15'd0, halted},      {15'd0, e.halt});
         chk({e.tag, " rd_en"},     {15'd0, imem_rd_en},  {15'd0, e.rd});
         chk({e.tag, " pc_hold"},   {15'd0, pc_hold},     {15'd0, e.hold});
         if (e.val) chk({e.tag, " pc2"}, if_id_pc2, e.pc2);
      end
   end

   task automatic push(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                       input logic [15:0] e_pc2, input logic e_val, input logic e_halt,
                       input logic e_rd, input logic e_hold);
      exp_t e;
      e.tag = tag; e.pc = e_pc; e.instr = e_instr; e.pc2 = e_pc2;
      e.val = e_val; e.halt = e_halt; e.rd = e_rd; e.hold = e_hold;
      sb.push_back(e);
   endtask

   // One cycle: inputs applied just after the rising edge, expectation is the
   // state seen during this cycle plus combinational outputs for these inputs.
   task automatic cyc(input string tag, input logic fl, input logic st, input logic rdy,
                      input logic [15:0] dat, input logic [15:0] npc,
                      input logic [15:0] e_pc, input logic [15:0] e_instr,
                      input logic [15:0] e_pc2, input logic e_val, input logic e_halt,
                      input logic e_rd, input logic e_hold);
      @(posedge clk);
      #1;
      flush = fl; stall = st; imem_ready = rdy; imem_data = dat; next_pc = npc;
      push(tag, e_pc, e_instr, e_pc2, e_val, e_halt, e_rd, e_hold);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      imem_data = 16'h0000; next_pc = 16'h0000;

      @(posedge clk);
      #1;
      push("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      // The first edge after release sees imem_ready=0: one bubble, WAIT_MEM.

      //   tag     fl st rdy data     npc       pc       instr    pc2      v  h  rd hold
      cyc("c1",  0, 0, 1, 16'h1111, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0);
      cyc("c2",  0, 0, 1, 16'h2222, 16'h0004, 16'h0002, 16'h1111, 16'h0002, 1, 0, 1, 0);
      cyc("c3",  0, 0, 1, 16'h3333, 16'h0006, 16'h0004, 16'h2222, 16'h0004, 1, 0, 1, 0);
      cyc("c4",  0, 0, 1, 16'h4444, 16'h0010, 16'h0006, 16'h3333, 16'h0006, 1, 0, 1, 0);
      // memory wait: three not-ready cycles at 0x0010
      cyc("w1",  0, 0, 0, 16'h0000, 16'h0012, 16'h0010, 16'h4444, 16'h0008, 1, 0, 1, 1);
      cyc("w2",  0, 0, 0, 16'h0000, 16'h0012, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1);
      cyc("w3",  0, 0, 0, 16'h0000, 16'h0012, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1);
      cyc("w4",  0, 0, 1, 16'h5555, 16'h0012, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 0);
      cyc("c9",  0, 0, 1, 16'h1234, 16'h0014, 16'h0012, 16'h5555, 16'h0012, 1, 0, 1, 0);
`ifdef FETCH_PERF_CNT_EN
      // accepts: c1..c4, w4 ; bubbles: post-reset edge plus w1..w3
      chk("fetch_cnt",  fetch_cnt,  16'd5);
      chk("bubble_cnt", bubble_cnt, 16'd4);
`endif
      // stall two cycles with IF/ID holding 0x1234, ready pulses ignored
      cyc("s1",  0, 1, 1, 16'h9999, 16'h0016, 16'h0014, 16'h1234, 16'h0014, 1, 0, 1, 1);
      cyc("s2",  0, 1, 1, 16'h9999, 16'h0016, 16'h0014, 16'h1234, 16'h0014, 1, 0, 1, 1);
      cyc("s3",  0, 0, 0, 16'h0000, 16'h0016, 16'h0014, 16'h1234, 16'h0014, 1, 0, 1, 1);
      // flush (with stall also high) during WAIT_MEM
      cyc("f1",  1, 1, 0, 16'h0000, 16'h0100, 16'h0014, 16'h0000, 16'h0000, 0, 0, 1, 0);
      cyc("f2",  0, 0, 1, 16'h6666, 16'h0020, 16'h0100, 16'h0000, 16'h0000, 0, 0, 1, 0);
      // HLT fetch at 0x0020, then flush to 0x0040
      cyc("h1",  0, 0, 1, 16'hF000, 16'h0022, 16'h0020, 16'h6666, 16'h0102, 1, 0, 1, 1);
      cyc("h2",  0, 0, 1, 16'h7777, 16'h0022, 16'h0020, 16'hF000, 16'h0022, 1, 1, 0, 1);
      cyc("h3",  1, 0, 0, 16'h0000, 16'h0040, 16'h0020, 16'h0000, 16'h0000, 0, 1, 0, 0);
      cyc("h4",  0, 0, 1, 16'h8888, 16'h0042, 16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 0);
      cyc("h5",  0, 0, 1, 16'hF001, 16'h0044, 16'h0042, 16'h8888, 16'h0042, 1, 0, 1, 1);
      cyc("h6",  0, 0, 1, 16'h0000, 16'h0044, 16'h0042, 16'hF001, 16'h0044, 1, 1, 0, 1);
      cyc("h7",  0, 0, 0, 16'h0000, 16'h0044, 16'h0042, 16'h0000, 16'h0000, 0, 1, 0, 1);

      // async reset pulse while halted: checked before any clock edge
      @(posedge clk);
      #1;
      imem_ready = 1'b0; flush = 1'b0; stall = 1'b0;
      #2 rst_n = 1'b0;
      push("rst_mid", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #1 rst_n = 1'b1;

      cyc("r1",  0, 0, 1, 16'h1111, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0);
      cyc("r2",  0, 0, 1, 16'h2222, 16'hFFFE, 16'h0002, 16'h1111, 16'h0002, 1, 0, 1, 0);
      // pc+2 wraps at 0xFFFE
      cyc("r3",  0, 0, 1, 16'h3333, 16'h0000, 16'hFFFE, 16'h2222, 16'h0004, 1, 0, 1, 0);
      cyc("r4",  0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h3333, 16'h0000, 1, 0, 1, 1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
